lifo_stack: RTL
===============

# lifo_stack

Parametrised hardware LIFO stack: the next generation of the processor's stack-pointer block, used for return-address and call-frame storage in the pipelined processor. It adds configurable width and depth, a synchronous reset, and an occupancy count. It also adds simultaneous push/pop (replace-top), flush, sticky overflow/underflow error flags, and registered status that is consistent with the pointer in the same cycle. The top-of-stack value is registered, so the fetch and decode stages read it with no combinational path through memory.

## Interface
- DATA_WIDTH, 32, width of each stack entry
- DEPTH, 16, number of entries; legal range 2..256
- CNT_W, $clog2(DEPTH+1), width of count (derived, not overridden)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- data_input  input  DATA_WIDTH  value to push
- stack_push  input  1  push request
- stack_pop  input  1  pop request
- flush  input  1  discard all entries
- clear_err  input  1  clear sticky error flags
- data_output  output  DATA_WIDTH  current top entry; 0 when empty
- count  output  CNT_W  number of valid entries, 0..DEPTH
- is_empty  output  1  count == 0
- is_full  output  1  count == DEPTH
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: pop attempted while empty

## Operation
- All decisions use the state before the clock edge (count, is_full, is_empty). All outputs are registered.
- Priority order: reset > flush > push/pop.
- Reset (synchronous):
  - count=0, is_empty=1, is_full=0, overflow=0, underflow=0, data_output=0.
  - Storage array is not reset.
- Flush:
  - count=0, data_output=0, is_empty=1, is_full=0.
  - push/pop in the same cycle are ignored.
  - Error flags are unchanged; clear_err is still honoured.
- Push only, not full: mem[count]<=data_input; count+1; data_output<=data_input.
- Push only, full: nothing stored; count unchanged; overflow<=1.
- Pop only, not empty: count-1.
  - data_output<=mem[count-2], or 0 if the new count is 0.
- Pop only, empty: no state change; underflow<=1.
- Push+pop, not empty (replace-top): mem[count-1]<=data_input; count unchanged; data_output<=data_input. Legal even when full; no overflow.
- Push+pop, empty: executes as push only (count 0->1) and sets underflow<=1.
- Neither request: hold all state.
- Error flags:
  - clear_err clears both flags.
  - If an error event occurs in the same cycle, the set wins.
- is_empty and is_full are derived from the next count value. They always agree with count on the same cycle; there is no one-cycle lag.
- Arithmetic: count is unsigned CNT_W bits and never wraps. Saturation is enforced by the full/empty checks, not by modular arithmetic.

## Timing
- One-cycle latency: an operation sampled at edge N is visible on data_output, count and the flags after edge N.
- Back-to-back operations every cycle are supported with no bubbles.
- A pop followed by a push on the next cycle uses the updated count.
- The data_output read path uses a registered top value. Pop lookahead (mem[count-2]) is a read of the array in the same cycle, made before the edge.
- Reset mid-operation: any push/pop in the reset cycle is discarded and no error flag is set.

## Test plan
- Reset, then push 0xA1, 0xB2, 0xC3 on consecutive cycles -> count=3, data_output=0xC3; then three pops -> data_output 0xB2, 0xA1, 0, and is_empty=1 after the third pop.
- With DEPTH=4: push 5 values 1..5 -> is_full=1 after the 4th push; the 5th push sets overflow=1, count stays 4, data_output=4. Then clear_err -> overflow=0.
- From empty, pop -> underflow=1, count=0, data_output=0. Then push+pop together with data_input=0x77 -> count=1, data_output=0x77, underflow remains 1.
- Push 0x10, 0x20, then push+pop with 0x99 -> count=2, data_output=0x99; then pop -> data_output=0x10.
- Push 3 values, then flush asserted together with push 0x55 -> count=0, is_empty=1, data_output=0. Next push 0x66 -> count=1, data_output=0x66.
- Push 2 values, assert reset together with push -> all outputs at reset values. clear_err asserted in the same cycle as a full-stack push -> overflow=1.

Source files
------------

// File: rtl/lifo_stack_if.sv
// Bundles the stack's request and status signals. The master side drives
// requests and write data; the slave side (the stack) returns registered
// top-of-stack data, the occupancy count and the status/error flags.
interface lifo_stack_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] data_input;
   logic                  stack_push;
   logic                  stack_pop;
   logic                  flush;
   logic                  clear_err;
   logic [DATA_WIDTH-1:0] data_output;
   logic [CNT_W-1:0]      count;
   logic                  is_empty;
   logic                  is_full;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output data_input, stack_push, stack_pop, flush, clear_err,
      input  data_output, count, is_empty, is_full, overflow, underflow
   );

   modport slave (
      input  data_input, stack_push, stack_pop, flush, clear_err,
      output data_output, count, is_empty, is_full, overflow, underflow
   );
endinterface

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack for return-address / call-frame storage.
// The top entry is held in its own register so readers never see a
// combinational path through the storage array. On a pop, the entry below
// the top is looked up before the edge and loaded into that register.
// Status flags are computed from the next count, so they always agree
// with the count that appears in the same cycle.
module lifo_stack #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
) (
   input logic        clk,
   input logic        reset,
   lifo_stack_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int AW    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // Storage and registered state
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [CNT_W-1:0]      r_count;
   logic [DATA_WIDTH-1:0] r_top;
   logic                  r_empty;
   logic                  r_full;
   logic                  r_ovf;
   logic                  r_udf;

   // Next-state values
   logic [CNT_W-1:0]      w_count_nxt;
   logic [DATA_WIDTH-1:0] w_top_nxt;
   logic                  w_wr_en;
   logic [AW-1:0]         w_wr_addr;
   logic [AW-1:0]         w_rd_idx;
   logic                  w_ovf_set;
   logic                  w_udf_set;
   logic                  w_ovf_nxt;
   logic                  w_udf_nxt;

   // Slot below the current top; only meaningful when count >= 2.
   assign w_rd_idx = AW'(r_count - CNT_W'(2));

   // Decode the request against the pre-edge state into next count, top and error events.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      w_count_nxt = r_count;
      w_top_nxt   = r_top;
      w_wr_en     = 1'b0;
      w_wr_addr   = '0;
      w_ovf_set   = 1'b0;
      w_udf_set   = 1'b0;

      if (bus.flush) begin
         w_count_nxt = '0;
         w_top_nxt   = '0;
      end else begin
         unique case ({bus.stack_push, bus.stack_pop})
            2'b10: begin
               if (r_full) begin
                  w_ovf_set = 1'b1;
               end else begin
                  w_wr_en     = 1'b1;
                  w_wr_addr   = AW'(r_count);
                  w_count_nxt = r_count + CNT_W'(1);
                  w_top_nxt   = bus.data_input;
               end
            end
            2'b01: begin
               if (r_empty) begin
                  w_udf_set = 1'b1;
               end else begin
                  w_count_nxt = r_count - CNT_W'(1);
                  w_top_nxt   = (r_count == CNT_W'(1)) ? '0 : r_mem[w_rd_idx];
               end
            end
            2'b11: begin
               if (r_empty) begin
                  // Nothing to replace: behaves as a plain push but still flags the pop.
                  w_udf_set   = 1'b1;
                  w_wr_en     = 1'b1;
                  w_wr_addr   = '0;
                  w_count_nxt = CNT_W'(1);
                  w_top_nxt   = bus.data_input;
               end else begin
                  // Replace-top: legal even when full, count unchanged.
                  w_wr_en   = 1'b1;
                  w_wr_addr = AW'(r_count - CNT_W'(1));
                  w_top_nxt = bus.data_input;
               end
            end
            default: ;
         endcase
      end

      // Sticky flags: a new error event in the same cycle beats clear_err.
      w_ovf_nxt = w_ovf_set | (r_ovf & ~bus.clear_err);
      w_udf_nxt = w_udf_set | (r_udf & ~bus.clear_err);
   end

   // Write the storage array; reset discards any write requested in its cycle.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; count gates validity, so clearing it would only cost logic.
      if (!reset && w_wr_en) begin
         r_mem[w_wr_addr] <= bus.data_input;
      end
   end

   // Register count, top value, status and sticky error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
         r_top   <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_top   <= w_top_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == DEPTH_C);
         r_ovf   <= w_ovf_nxt;
         r_udf   <= w_udf_nxt;
      end
   end

   assign bus.data_output = r_top;
   assign bus.count       = r_count;
   assign bus.is_empty    = r_empty;
   assign bus.is_full     = r_full;
   assign bus.overflow    = r_ovf;
   assign bus.underflow   = r_udf;
endmodule
